poly_dec_fir: RTL and testbench
===============================

POLY_DEC_FIR -- requirements
Module: poly_dec_fir

Interface
REQ-001 Parameter WIN, 8, signed input sample width.
REQ-002 Parameter WCOEF, 12, signed coefficient width.
REQ-003 Parameter NTAPS, 21, filter length, range 2..256.
REQ-004 Parameter DEC_MAX, 8, largest decimation factor, range 1..64.
REQ-005 Derived constant WACC = WIN + WCOEF + clog2(NTAPS), accumulator and output width.
REQ-006 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 X  in  WIN  signed input sample.
REQ-009 in_valid / in_ready  in / out  1  input handshake; a sample is accepted when both are high.
REQ-010 dec_factor  in  clog2(DEC_MAX+1)  runtime decimation factor; value 0 SHALL be treated as 1.
REQ-011 coef_we / coef_addr / coef_data  in  1 / clog2(NTAPS) / WCOEF  coefficient write port; coef_data is signed.
REQ-012 flush  in  1  synchronous pipeline clear.
REQ-013 Y  out  WACC  signed filter output, full precision.
REQ-014 out_valid / out_ready  out / in  1  output handshake; transfer when both are high.
REQ-015 busy  out  1  high in MAC or OUT state.

Function
REQ-016 States: COLLECT, MAC, OUT; in_ready SHALL equal (state==COLLECT) and not flush.
REQ-017 On accept: delay line shifts, d[0] <= X and d[k] <= d[k-1]; phase counter increments.
REQ-018 On an accept with phase >= dec_factor-1: phase <= 0, acc <= 0, tap <= 0, state <= MAC.
REQ-019 In MAC: each cycle acc <= acc + d[tap]*c[tap] (signed, sign-extended to WACC), tap increments; after tap NTAPS-1, state <= OUT.
REQ-020 Latency: trigger accept at cycle t; MAC cycles t+1..t+NTAPS; out_valid=1 and Y=acc at cycle t+NTAPS+1.
REQ-021 In OUT: Y and out_valid are held until out_ready=1; the state then returns to COLLECT in the next cycle.
REQ-022 Y = sum over k of d[k]*c[k], with d[0] the newest sample; by REQ-005 no overflow is possible, and no rounding or saturation is applied.
REQ-023 A coefficient write SHALL take effect only in COLLECT with coef_addr < NTAPS; otherwise it is silently dropped.
REQ-024 dec_factor may change at any time; the comparison in REQ-018 uses its current value, so a decrease below phase+1 triggers on the next accept.
REQ-025 flush (any state): clear delay line, phase, acc, tap and out_valid; state <= COLLECT; coefficients are retained; any pending or in-progress output is discarded.
REQ-026 flush together with in_valid: flush wins and the sample is not accepted.
REQ-027 No accept is possible in MAC or OUT, so no input sample is lost under backpressure.

Reset
REQ-028 When reset=0 at a clock edge: state=COLLECT; delay line, coefficients, phase, tap, acc, Y, out_valid and busy are all 0.
REQ-029 Reset mid-MAC or mid-OUT aborts the operation with no output.
REQ-030 Reset has priority over flush and over coefficient writes.

Structure
REQ-031 Package poly_fir_pkg SHALL hold the state enum, the clog2 function and the WACC derivation.
REQ-032 Sub-module poly_fir_coef_bank: NTAPS x WCOEF register file with one write port and one combinational read port indexed by tap.
REQ-033 Only one multiplier SHALL be instantiated (time-multiplexed MAC).

Verification (WIN=8, WCOEF=12, NTAPS=21, DEC_MAX=8)
REQ-034 Impulse test: c[k]=k+1, dec_factor=1, X=1 then zeros -> Y = 1,2,...,21, then 0; each out_valid at accept+22 cycles.
REQ-035 Decimation test: all c=1, dec_factor=4, X=10 constant -> Y = 40,80,120,160,200,210,210,...
REQ-036 Extremes test: all c=-2048, X=-128, dec_factor=1 -> after 21 samples Y=5505024 with no wrap.
REQ-037 Backpressure test: out_ready=0 for 10 cycles -> Y stable, in_ready=0, busy=1; the next accepted sample continues the sequence with no loss.
REQ-038 Flush test: flush at MAC cycle 5 -> no out_valid for that window; the next output with dec_factor=1 and X=7 equals 7*c[0].
REQ-039 Write-gating test: coefficient write during MAC, or with coef_addr=21 -> coefficients unchanged; reset mid-MAC -> all outputs 0 next cycle.

Source files
------------

// File: rtl/poly_fir_pkg.sv
// Shared types and width helpers for the polyphase decimating FIR.
package poly_fir_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    MAC     = 2'd1,
    OUT     = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Full-precision accumulator width: the sum of NTAPS products cannot overflow it.
  function automatic int calc_wacc(input int win, input int wcoef, input int ntaps);
    return win + wcoef + clog2(ntaps);
  endfunction

endpackage

// File: rtl/poly_fir_coef_bank.sv
// Coefficient register file: one synchronous write port, one combinational read port.
module poly_fir_coef_bank
  import poly_fir_pkg::*;
#(
  parameter int   WCOEF = 12,
  parameter int   NTAPS = 21,
  localparam int  TW    = clog2(NTAPS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [TW-1:0]           waddr,
  input  logic signed [WCOEF-1:0] wdata,
  input  logic [TW-1:0]           raddr,
  output logic signed [WCOEF-1:0] rdata
);

  logic signed [WCOEF-1:0] mem [NTAPS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NTAPS; k++) mem[k] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/poly_dec_fir.sv
// Decimating FIR: collects dec_factor samples, then runs one time-multiplexed MAC
// pass over all taps and holds the full-precision result until it is taken.
module poly_dec_fir
  import poly_fir_pkg::*;
#(
  parameter int   WIN     = 8,
  parameter int   WCOEF   = 12,
  parameter int   NTAPS   = 21,
  parameter int   DEC_MAX = 8,
  localparam int  WACC    = calc_wacc(WIN, WCOEF, NTAPS),
  localparam int  TW      = clog2(NTAPS),
  localparam int  DW      = clog2(DEC_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIN-1:0]   X,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW-1:0]           dec_factor,
  input  logic                    coef_we,
  input  logic [TW-1:0]           coef_addr,
  input  logic signed [WCOEF-1:0] coef_data,
  input  logic                    flush,
  output logic signed [WACC-1:0]  Y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int            PW       = WIN + WCOEF;
  localparam logic [TW-1:0] LAST_TAP = TW'(NTAPS - 1);

  state_t                  state_q, state_d;
  logic signed [WIN-1:0]   dline [NTAPS];
  logic [TW-1:0]           tap;
  logic [DW-1:0]           phase;
  logic [DW-1:0]           dec_eff;
  logic signed [WACC-1:0]  acc;
  logic signed [WCOEF-1:0] coef_rd;
  logic signed [PW-1:0]    prod;
  logic                    accept;
  logic                    trigger;
  logic                    coef_wr_en;

  assign dec_eff    = (dec_factor == '0) ? DW'(1) : dec_factor;
  assign accept     = in_valid && (state_q == COLLECT) && !flush;
  assign trigger    = phase >= (dec_eff - DW'(1));
  assign coef_wr_en = coef_we && (state_q == COLLECT) && (int'(coef_addr) < NTAPS);

  poly_fir_coef_bank #(
    .WCOEF (WCOEF),
    .NTAPS (NTAPS)
  ) u_coef_bank (
    .clk   (clk),
    .reset (reset),
    .we    (coef_wr_en),
    .waddr (coef_addr),
    .wdata (coef_data),
    .raddr (tap),
    .rdata (coef_rd)
  );

  // The single shared multiplier; operands widened first so the product is exact.
  assign prod = PW'(dline[tap]) * PW'(coef_rd);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      COLLECT: begin
        in_ready = !flush;
        if (accept && trigger) state_d = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (tap == LAST_TAP) state_d = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
    if (flush) state_d = COLLECT;
  end

  // Delay line, phase counter and MAC accumulator; flush clears them like reset.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      for (int k = 0; k < NTAPS; k++) dline[k] <= '0;
      phase <= '0;
      tap   <= '0;
      acc   <= '0;
    end else begin
      if (accept) begin
        dline[0] <= X;
        for (int k = 1; k < NTAPS; k++) dline[k] <= dline[k-1];
        if (trigger) begin
          phase <= '0;
          acc   <= '0;
          tap   <= '0;
        end else begin
          phase <= phase + DW'(1);
        end
      end
      if (state_q == MAC) begin
        acc <= acc + {{(WACC-PW){prod[PW-1]}}, prod};
        tap <= (tap == LAST_TAP) ? '0 : tap + TW'(1);
      end
    end
  end

  assign Y = acc;

endmodule

// File: tb/tb_poly_dec_fir.sv
// Scoreboard bench for poly_dec_fir: a cycle model predicts handshakes and results.
module tb_poly_dec_fir;

  localparam int WIN   = 8;
  localparam int WCOEF = 12;
  localparam int NTAPS = 21;
  localparam int WACC  = 25;
  localparam int TW    = 5;
  localparam int DW    = 4;

  logic                    clk;
  logic                    reset;
  logic signed [WIN-1:0]   X;
  logic                    in_valid;
  logic                    in_ready;
  logic [DW-1:0]           dec_factor;
  logic                    coef_we;
  logic [TW-1:0]           coef_addr;
  logic signed [WCOEF-1:0] coef_data;
  logic                    flush;
  logic signed [WACC-1:0]  Y;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;

  int checks = 0;
  int errors = 0;

  poly_dec_fir #(
    .WIN     (8),
    .WCOEF   (12),
    .NTAPS   (21),
    .DEC_MAX (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .X          (X),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dec_factor (dec_factor),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .flush      (flush),
    .Y          (Y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {M_COLLECT, M_MAC, M_OUT} mst_t;

  mst_t   m_st = M_COLLECT;
  bit     m_known = 1'b0;
  int     m_cnt = 0;
  int     m_phase = 0;
  longint m_d [NTAPS];
  longint m_c [NTAPS];
  longint exp_q [$];
  longint obs_q [$];

  // Reference model, evaluated mid-cycle on stable inputs.
  initial begin : monitor
    mst_t   nxt;
    int     dec;
    longint s;
    forever begin
      @(negedge clk);
      if (m_known) begin
        checks++;
        if (in_ready !== (m_st == M_COLLECT && !flush)) begin
          errors++;
          $display("FAIL in_ready t=%0t got %b exp %b", $time, in_ready, (m_st == M_COLLECT && !flush));
        end
        checks++;
        if (out_valid !== (m_st == M_OUT)) begin
          errors++;
          $display("FAIL out_valid t=%0t got %b exp %b", $time, out_valid, (m_st == M_OUT));
        end
        checks++;
        if (busy !== (m_st != M_COLLECT)) begin
          errors++;
          $display("FAIL busy t=%0t got %b exp %b", $time, busy, (m_st != M_COLLECT));
        end
        if (m_st == M_OUT) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL y_scoreboard t=%0t got %0d exp none", $time, Y);
          end else if (longint'(Y) !== exp_q[0]) begin
            errors++;
            $display("FAIL y_scoreboard t=%0t got %0d exp %0d", $time, Y, exp_q[0]);
          end
        end
      end
      nxt = m_st;
      if (!reset) begin
        nxt = M_COLLECT;
        for (int k = 0; k < NTAPS; k++) begin
          m_d[k] = 0;
          m_c[k] = 0;
        end
        m_phase = 0;
        exp_q.delete();
        m_known = 1'b1;
      end else if (m_known) begin
        if (coef_we && m_st == M_COLLECT && int'(coef_addr) < NTAPS)
          m_c[coef_addr] = longint'(coef_data);
        if (flush) begin
          nxt = M_COLLECT;
          for (int k = 0; k < NTAPS; k++) m_d[k] = 0;
          m_phase = 0;
          exp_q.delete();
        end else begin
          case (m_st)
            M_COLLECT: if (in_valid) begin
              for (int k = NTAPS - 1; k > 0; k--) m_d[k] = m_d[k-1];
              m_d[0] = longint'(X);
              dec = (dec_factor == 0) ? 1 : int'(dec_factor);
              if (m_phase >= dec - 1) begin
                m_phase = 0;
                s = 0;
                for (int k = 0; k < NTAPS; k++) s += m_d[k] * m_c[k];
                exp_q.push_back(s);
                m_cnt = 0;
                nxt = M_MAC;
              end else begin
                m_phase++;
              end
            end
            M_MAC: begin
              m_cnt++;
              if (m_cnt == NTAPS) nxt = M_OUT;
            end
            M_OUT: if (out_ready) begin
              obs_q.push_back(longint'(Y));
              if (exp_q.size() != 0) void'(exp_q.pop_front());
              nxt = M_COLLECT;
            end
            default: nxt = M_COLLECT;
          endcase
        end
      end
      m_st = nxt;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int a, input int v);
    coef_we   = 1'b1;
    coef_addr = TW'(a);
    coef_data = WCOEF'(v);
    step();
    coef_we   = 1'b0;
  endtask

  task automatic send(input int x);
    bit done = 1'b0;
    in_valid = 1'b1;
    X        = WIN'(x);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout got in_ready=0 exp accept within 200 cycles");
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_st != M_COLLECT) && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_timeout got pending=%0d exp 0", exp_q.size());
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if (Y !== '0) begin errors++; $display("FAIL reset_y got %0d exp 0", Y); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    reset = 1'b1;
    step();
    obs_q.delete();
    dec_factor = 4'd1;
    send(5);
    drain();
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 0) begin
      errors++;
      $display("FAIL reset_coefs got n=%0d y=%0d exp n=1 y=0", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : -1);
    end
  endtask

  task automatic test_impulse();
    longint e;
    do_flush();
    for (int k = 0; k < NTAPS; k++) write_coef(k, k + 1);
    dec_factor = 4'd1;
    obs_q.delete();
    send(1);
    for (int k = 0; k < NTAPS; k++) send(0);
    drain();
    for (int k = 0; k < NTAPS + 1; k++) begin
      e = (k < NTAPS) ? longint'(k + 1) : 0;
      checks++;
      if (k >= obs_q.size() || obs_q[k] !== e) begin
        errors++;
        $display("FAIL impulse[%0d] got %0d exp %0d", k, (k < obs_q.size()) ? obs_q[k] : -1, e);
      end
    end
  endtask

  task automatic test_decimation();
    longint e [7] = '{40, 80, 120, 160, 200, 210, 210};
    do_flush();
    for (int k = 0; k < NTAPS; k++) write_coef(k, 1);
    dec_factor = 4'd4;
    obs_q.delete();
    for (int i = 0; i < 28; i++) send(10);
    drain();
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (k >= obs_q.size() || obs_q[k] !== e[k]) begin
        errors++;
        $display("FAIL decimation[%0d] got %0d exp %0d", k, (k < obs_q.size()) ? obs_q[k] : -1, e[k]);
      end
    end
  endtask

  task automatic test_dec_change();
    longint e [3] = '{9, 13, 18};
    do_flush();
    obs_q.delete();
    dec_factor = 4'd4;
    send(3);
    send(3);
    dec_factor = 4'd2;
    send(3);
    drain();
    dec_factor = 4'd0;
    send(4);
    drain();
    send(5);
    drain();
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL dec_change_count got %0d exp 3", obs_q.size());
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= obs_q.size() || obs_q[k] !== e[k]) begin
        errors++;
        $display("FAIL dec_change[%0d] got %0d exp %0d", k, (k < obs_q.size()) ? obs_q[k] : -1, e[k]);
      end
    end
  endtask

  task automatic test_extremes();
    longint e;
    do_flush();
    for (int k = 0; k < NTAPS; k++) write_coef(k, -2048);
    dec_factor = 4'd1;
    obs_q.delete();
    for (int i = 0; i < NTAPS; i++) send(-128);
    drain();
    for (int k = 0; k < NTAPS; k++) begin
      e = longint'(k + 1) * 262144;
      checks++;
      if (k >= obs_q.size() || obs_q[k] !== e) begin
        errors++;
        $display("FAIL extremes[%0d] got %0d exp %0d", k, (k < obs_q.size()) ? obs_q[k] : -1, e);
      end
    end
    checks++;
    if (obs_q.size() != NTAPS || obs_q[NTAPS-1] !== 64'sd5505024) begin
      errors++;
      $display("FAIL extremes_final got %0d exp 5505024",
               (obs_q.size() == NTAPS) ? obs_q[NTAPS-1] : -1);
    end
  endtask

  task automatic test_backpressure();
    logic signed [WACC-1:0] y0;
    int n = 0;
    do_flush();
    for (int k = 0; k < NTAPS; k++) write_coef(k, k + 1);
    dec_factor = 4'd1;
    obs_q.delete();
    out_ready = 1'b0;
    send(3);
    while (out_valid !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (n >= 60) begin errors++; $display("FAIL bp_wait got out_valid=0 exp 1"); end
    y0 = Y;
    checks++;
    if (y0 !== 25'sd3) begin errors++; $display("FAIL bp_first_y got %0d exp 3", y0); end
    in_valid = 1'b1;
    X = 8'sd5;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (Y !== y0 || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d] got y=%0d rdy=%b busy=%b ov=%b exp y=%0d rdy=0 busy=1 ov=1",
                 i, Y, in_ready, busy, out_valid, y0);
      end
    end
    out_ready = 1'b1;
    send(5);
    drain();
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 3 || obs_q[1] !== 11) begin
      errors++;
      $display("FAIL bp_sequence got n=%0d last=%0d exp n=2 3,11", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : -1);
    end
  endtask

  task automatic test_flush();
    do_flush();
    write_coef(0, 3);
    dec_factor = 4'd1;
    obs_q.delete();
    send(9);
    repeat (5) step();
    do_flush();
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_output[%0d] got %b exp 0", i, out_valid);
      end
    end
    send(7);
    drain();
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 21) begin
      errors++;
      $display("FAIL flush_next got n=%0d y=%0d exp n=1 y=21", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : -1);
    end
  endtask

  task automatic test_write_gating();
    do_flush();
    write_coef(0, 1);
    dec_factor = 4'd1;
    obs_q.delete();
    send(1);
    coef_we   = 1'b1;
    coef_addr = 5'd0;
    coef_data = 12'sd100;
    repeat (5) step();
    coef_we = 1'b0;
    drain();
    write_coef(21, 55);
    do_flush();
    send(2);
    drain();
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 1 || obs_q[1] !== 2) begin
      errors++;
      $display("FAIL gating got n=%0d last=%0d exp n=2 1,2", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : -1);
    end
    send(4);
    repeat (5) step();
    reset = 1'b0;
    step();
    checks++;
    if (Y !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mac got y=%0d ov=%b busy=%b exp 0 0 0", Y, out_valid, busy);
    end
    reset = 1'b1;
    step();
    obs_q.delete();
    send(6);
    drain();
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 0) begin
      errors++;
      $display("FAIL after_reset got n=%0d y=%0d exp n=1 y=0", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : -1);
    end
  endtask

  initial begin
    reset      = 1'b0;
    in_valid   = 1'b0;
    X          = '0;
    dec_factor = 4'd1;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_data  = '0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    test_reset();
    test_impulse();
    test_decimation();
    test_dec_change();
    test_extremes();
    test_backpressure();
    test_flush();
    test_write_gating();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
